// File: rtl/conv3x3_multimode.sv
// conv3x3_multimode
//   Multi-channel 3x3 neighbourhood filter with a kernel mode chosen per beat:
//   0 pass-through, 1 Gaussian (1-2-1), 2 sharpen (5P-E), 3 Laplacian magnitude.
//   Four register stages: window capture, neighbourhood sums, mode combine,
//   clamp/output. The whole pipeline advances together on a single enable.
//   Valid/ready back-pressure is supported. A line-end flag travels with each beat.
//
// Configuration macro: CONV3X3_ROUND_EN
//   Defined:   Gaussian adds 8 before >>4, giving round-half-up.
//   Undefined: Gaussian truncates.
//
// Ports
//   clk             clock, rising edge
//   reset           synchronous, active-high
//   s_matrix_data   CHANNELS windows of 9 pixels; element (r,c) of channel k
//                   is at k*9*DATA_WIDTH + (r*3+c)*DATA_WIDTH
//   s_matrix_mode   kernel select for this beat
//   s_matrix_last   line-end marker for this beat
//   s_matrix_valid  input beat valid
//   s_matrix_ready  input beat accepted when valid & ready
//   m_result_data   CHANNELS clamped pixels, channel k at k*DATA_WIDTH
//   m_result_last   line-end marker of the result beat
//   m_result_valid  result beat valid
//   m_result_ready  downstream accept
module conv3x3_multimode #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [9*DATA_WIDTH*CHANNELS-1:0] s_matrix_data,
  input  logic [1:0]                       s_matrix_mode,
  input  logic                             s_matrix_last,
  input  logic                             s_matrix_valid,
  output logic                             s_matrix_ready,
  output logic [DATA_WIDTH*CHANNELS-1:0]   m_result_data,
  output logic                             m_result_last,
  output logic                             m_result_valid,
  input  logic                             m_result_ready
);

  localparam int WW = 9*DATA_WIDTH*CHANNELS;
  localparam int SW = DATA_WIDTH + 4;
  localparam int VW = DATA_WIDTH + 5;

`ifdef CONV3X3_ROUND_EN
  localparam logic [SW-1:0] RND = SW'(8);
`else
  localparam logic [SW-1:0] RND = SW'(0);
`endif

  localparam logic signed [VW-1:0] PIX_MAX = VW'(2**DATA_WIDTH - 1);

  function automatic logic [DATA_WIDTH-1:0] pix(input logic [WW-1:0] win,
                                                input int ch, input int idx);
    return win[ch*9*DATA_WIDTH + idx*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [VW-1:0] v);
    if (v < 0)             return '0;
    else if (v > PIX_MAX)  return '1;
    else                   return v[DATA_WIDTH-1:0];
  endfunction

  logic en;

  logic [WW-1:0]         win_p0;
  logic [1:0]            mode_p0, mode_p1;
  logic                  last_p0, last_p1, last_p2;
  logic                  vld_p0, vld_p1, vld_p2, vld_p3;

  logic [SW-1:0]         c_p1   [CHANNELS];
  logic [SW-1:0]         e_p1   [CHANNELS];
  logic [DATA_WIDTH-1:0] ctr_p1 [CHANNELS];

  logic signed [VW-1:0]  v_comb [CHANNELS];
  logic signed [VW-1:0]  v_p2   [CHANNELS];

  logic [DATA_WIDTH*CHANNELS-1:0] res_p3;
  logic                           last_p3;

  // A frozen output stalls every stage; an empty output lets bubbles be overwritten.
  assign en             = ~vld_p3 | m_result_ready;
  assign s_matrix_ready = en & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else if (en) begin
      vld_p0 <= s_matrix_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
    end
  end

  // Stage 1: capture window, mode and last
  always_ff @(posedge clk) begin
    if (en) begin
      win_p0  <= s_matrix_data;
      mode_p0 <= s_matrix_mode;
      last_p0 <= s_matrix_last;
    end
  end

  // Stage 2: corner sum, edge sum and centre per channel
  always_ff @(posedge clk) begin
    if (en) begin
      mode_p1 <= mode_p0;
      last_p1 <= last_p0;
      for (int k = 0; k < CHANNELS; k++) begin
        c_p1[k]   <= SW'(pix(win_p0, k, 0)) + SW'(pix(win_p0, k, 2))
                   + SW'(pix(win_p0, k, 6)) + SW'(pix(win_p0, k, 8));
        e_p1[k]   <= SW'(pix(win_p0, k, 1)) + SW'(pix(win_p0, k, 3))
                   + SW'(pix(win_p0, k, 5)) + SW'(pix(win_p0, k, 7));
        ctr_p1[k] <= pix(win_p0, k, 4);
      end
    end
  end

  // Stage 3: combine by mode into a signed value wide enough for every kernel
  always_comb begin : combine
    logic [SW-1:0]        g;
    logic signed [VW-1:0] d;
    for (int k = 0; k < CHANNELS; k++) begin
      v_comb[k] = '0;
      g = (SW'(ctr_p1[k]) << 2) + (e_p1[k] << 1) + c_p1[k] + RND;
      d = $signed((VW'(ctr_p1[k]) << 2) - VW'(e_p1[k]));
      case (mode_p1)
        2'd0: v_comb[k] = $signed(VW'(ctr_p1[k]));
        2'd1: v_comb[k] = $signed(VW'(g >> 4));
        2'd2: v_comb[k] = d + $signed(VW'(ctr_p1[k]));
        default: v_comb[k] = (d < 0) ? -d : d;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      last_p2 <= last_p1;
      for (int k = 0; k < CHANNELS; k++) v_p2[k] <= v_comb[k];
    end
  end

  // Stage 4: clamp to pixel range and register the result
  always_ff @(posedge clk) begin
    if (reset) begin
      res_p3  <= '0;
      last_p3 <= 1'b0;
    end else if (en) begin
      last_p3 <= last_p2;
      for (int k = 0; k < CHANNELS; k++)
        res_p3[k*DATA_WIDTH +: DATA_WIDTH] <= sat(v_p2[k]);
    end
  end

  assign m_result_data  = res_p3;
  assign m_result_last  = last_p3;
  assign m_result_valid = vld_p3;

endmodule
